// File: rtl/dice_tid_disp_pkg.sv
// Shared types and constants for the thread-ID dispatcher feeding the per-bank RF address converter.
package dice_tid_disp_pkg;

    localparam int unsigned DEPTH      = 512;
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam int unsigned II_WIDTH   = 4;

    // Largest legal block size; larger descriptors are clamped to this.
    localparam logic [CNT_WIDTH-1:0] MAX_COUNT = CNT_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } tid_disp_state_e;

    function automatic logic [CNT_WIDTH-1:0] clamp_count(input logic [CNT_WIDTH-1:0] count);
        return (count > MAX_COUNT) ? MAX_COUNT : count;
    endfunction

    // An initiation interval of zero behaves as one tid per cycle.
    function automatic logic [II_WIDTH-1:0] norm_ii(input logic [II_WIDTH-1:0] ii);
        return (ii == '0) ? II_WIDTH'(1) : ii;
    endfunction

endpackage

// File: rtl/dice_tid_dispatcher.sv
// Accepts a thread-block descriptor and issues consecutive tids, one per initiation
// interval, under downstream backpressure; pulses blk_done when the block is fully issued.
module dice_tid_dispatcher
    import dice_tid_disp_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  blk_valid,
    output logic                  blk_ready,
    input  logic [ADDR_WIDTH-1:0] blk_tid_base,
    input  logic [ADDR_WIDTH:0]   blk_tid_count,
    input  logic [II_WIDTH-1:0]   cfg_ii,
    input  logic                  abort,
    output logic                  disp_valid,
    input  logic                  disp_ready,
    output logic [ADDR_WIDTH-1:0] disp_tid,
    output logic                  disp_last,
    output logic                  blk_done,
    output logic                  busy
);

    tid_disp_state_e       state_q, state_d;
    logic [ADDR_WIDTH-1:0] tid_q, tid_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  offset_q, offset_d;
    logic [II_WIDTH-1:0]   ii_q, ii_d;
    logic [II_WIDTH-1:0]   gap_q, gap_d;
    logic                  last_q, last_d;

    logic                  fire;
    logic [CNT_WIDTH-1:0]  clamped_count;
    logic [CNT_WIDTH-1:0]  next_offset;

    assign fire          = (state_q == ISSUE) && disp_ready;
    assign clamped_count = clamp_count(blk_tid_count);
    assign next_offset   = offset_q + CNT_WIDTH'(1);

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        tid_d    = tid_q;
        count_d  = count_q;
        offset_d = offset_q;
        ii_d     = ii_q;
        gap_d    = gap_q;
        last_d   = last_q;

        case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    count_d  = clamped_count;
                    ii_d     = norm_ii(cfg_ii);
                    tid_d    = blk_tid_base;
                    offset_d = '0;
                    last_d   = (clamped_count == CNT_WIDTH'(1));
                    state_d  = (clamped_count == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (fire) begin
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        tid_d    = tid_q + ADDR_WIDTH'(1);
                        offset_d = next_offset;
                        last_d   = (next_offset == (count_q - CNT_WIDTH'(1)));
                        if (ii_q > II_WIDTH'(1)) begin
                            state_d = GAP;
                            gap_d   = ii_q - II_WIDTH'(1);
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q <= II_WIDTH'(1)) begin
                    state_d = ISSUE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - II_WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fire coincident with abort has already been consumed downstream.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tid_q    <= '0;
            count_q  <= '0;
            offset_q <= '0;
            ii_q     <= II_WIDTH'(1);
            gap_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tid_q    <= tid_d;
            count_q  <= count_d;
            offset_q <= offset_d;
            ii_q     <= ii_d;
            gap_q    <= gap_d;
            last_q   <= last_d;
        end
    end

    // Outputs decode from registered state only; disp_ready never reaches disp_valid.
    assign disp_valid = (state_q == ISSUE);
    assign disp_tid   = tid_q;
    assign disp_last  = last_q && (state_q == ISSUE);
    assign blk_done   = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign blk_ready  = (state_q == IDLE);

endmodule

// File: tb/tb_dice_tid_dispatcher.sv
// Randomized self-checking bench for dice_tid_dispatcher against an interval-level reference model.
module tb_dice_tid_dispatcher;

    localparam int DEPTH = 512;

    logic       clk;
    logic       reset;
    logic       blk_valid;
    logic       blk_ready;
    logic [8:0] blk_tid_base;
    logic [9:0] blk_tid_count;
    logic [3:0] cfg_ii;
    logic       abort;
    logic       disp_valid;
    logic       disp_ready;
    logic [8:0] disp_tid;
    logic       disp_last;
    logic       blk_done;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    dice_tid_dispatcher dut (
        .clk          (clk),
        .reset        (reset),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_tid_base (blk_tid_base),
        .blk_tid_count(blk_tid_count),
        .cfg_ii       (cfg_ii),
        .abort        (abort),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_tid     (disp_tid),
        .disp_last    (disp_last),
        .blk_done     (blk_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Model works in intervals k after the accept edge: tid i of the block is valid from
    // interval next_k until it fires; the next tid appears ii intervals after that fire.
    // rmode: 0 ready always high, 1 random ready, 2 ready low for the first 3 valid intervals.
    task automatic run_block(input int base, input int cnt, input int ii, input int rmode,
                             input int abort_fire, input bit abort_on_accept, input int want_issued);
        int n, eii, idx, next_k, done_k, stall, abort_k, issued, k;
        bit aborted, vexp, busy_exp, rdy, fin;
        n       = (cnt > DEPTH) ? DEPTH : cnt;
        eii     = (ii == 0) ? 1 : ii;
        idx     = 0;
        next_k  = 1;
        done_k  = (n == 0) ? 1 : -1;
        stall   = 3;
        abort_k = 0;
        issued  = 0;
        aborted = 1'b0;
        fin     = 1'b0;

        check_eq("ready_before_accept", 32'(blk_ready), 32'd1);
        blk_valid     = 1'b1;
        blk_tid_base  = 9'(base);
        blk_tid_count = 10'(cnt);
        cfg_ii        = 4'(ii);
        abort         = abort_on_accept;
        disp_ready    = 1'($urandom_range(0, 1));
        @(negedge clk);
        blk_valid = 1'b0;
        abort     = 1'b0;

        for (k = 1; k <= 20000 && !fin; k++) begin
            vexp     = !aborted && (idx < n) && (k >= next_k);
            busy_exp = !aborted && (done_k < 0 || k <= done_k);
            check_eq("disp_valid", 32'(disp_valid), 32'(vexp));
            check_eq("busy", 32'(busy), 32'(busy_exp));
            check_eq("blk_ready", 32'(blk_ready), 32'(!busy_exp));
            check_eq("blk_done", 32'(blk_done), 32'(!aborted && k == done_k));
            if (vexp) begin
                check_eq("disp_tid", 32'(disp_tid), 32'((base + idx) % DEPTH));
                check_eq("disp_last", 32'(disp_last), 32'(idx == n - 1));
            end
            if ((!aborted && done_k >= 0 && k > done_k) || (aborted && k >= abort_k + 3)) begin
                fin = 1'b1;
            end else begin
                case (rmode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 3) != 0);
                    default: begin
                        rdy = 1'b1;
                        if (vexp && stall > 0) begin
                            rdy = 1'b0;
                            stall--;
                        end
                    end
                endcase
                disp_ready = rdy;
                if (vexp && rdy) begin
                    idx++;
                    issued++;
                    if (idx == n) done_k = k + 1;
                    else next_k = k + eii;
                    if (abort_fire == idx) begin
                        abort   = 1'b1;
                        aborted = 1'b1;
                        abort_k = k;
                    end
                end
                // Descriptor inputs and cfg_ii wander while busy; they must not matter.
                cfg_ii = 4'($urandom_range(0, 15));
                if (busy_exp) begin
                    blk_valid     = 1'($urandom_range(0, 1));
                    blk_tid_base  = 9'($urandom_range(0, DEPTH - 1));
                    blk_tid_count = 10'($urandom_range(0, 1023));
                end else begin
                    blk_valid = 1'b0;
                end
                @(negedge clk);
                abort = 1'b0;
            end
        end
        if (!fin) check_eq("block_timeout", 32'd0, 32'd1);
        if (want_issued >= 0) check_eq("tids_issued", 32'(issued), 32'(want_issued));
        blk_valid  = 1'b0;
        abort      = 1'b0;
        disp_ready = 1'b0;
    endtask

    initial begin
        int b, c, ii, af;
        reset         = 1'b1;
        blk_valid     = 1'b0;
        blk_tid_base  = '0;
        blk_tid_count = '0;
        cfg_ii        = '0;
        abort         = 1'b0;
        disp_ready    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_disp_valid", 32'(disp_valid), 32'd0);
        check_eq("rst_disp_tid", 32'(disp_tid), 32'd0);
        check_eq("rst_disp_last", 32'(disp_last), 32'd0);
        check_eq("rst_blk_done", 32'(blk_done), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_blk_ready", 32'(blk_ready), 32'd1);

        // Directed cases
        run_block(0, 4, 1, 0, 0, 1'b0, 4);
        run_block(510, 4, 1, 0, 0, 1'b0, 4);
        run_block(8, 3, 3, 0, 0, 1'b0, 3);
        run_block(5, 2, 1, 2, 0, 1'b0, 2);
        run_block(77, 0, 1, 0, 0, 1'b0, 0);
        run_block(3, 600, 1, 0, 0, 1'b0, 512);
        run_block(20, 8, 1, 0, 2, 1'b0, 2);
        run_block(40, 5, 0, 1, 0, 1'b1, 5);
        run_block(511, 1, 15, 1, 0, 1'b0, 1);
        run_block(100, 6, 4, 2, 6, 1'b0, 6);

        // Abort while idle is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("idle_abort_ready", 32'(blk_ready), 32'd1);
        check_eq("idle_abort_busy", 32'(busy), 32'd0);

        // Reset in the middle of a block
        blk_valid     = 1'b1;
        blk_tid_base  = 9'd100;
        blk_tid_count = 10'd50;
        cfg_ii        = 4'd2;
        @(negedge clk);
        blk_valid  = 1'b0;
        disp_ready = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_disp_valid", 32'(disp_valid), 32'd0);
        check_eq("midrst_disp_tid", 32'(disp_tid), 32'd0);
        check_eq("midrst_disp_last", 32'(disp_last), 32'd0);
        check_eq("midrst_blk_done", 32'(blk_done), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        reset      = 1'b0;
        disp_ready = 1'b0;
        @(negedge clk);
        check_eq("midrst_blk_done_after", 32'(blk_done), 32'd0);
        check_eq("midrst_blk_ready", 32'(blk_ready), 32'd1);

        // Randomized blocks
        for (int t = 0; t < 40; t++) begin
            b  = $urandom_range(0, DEPTH - 1);
            ii = $urandom_range(0, 5);
            if ($urandom_range(0, 7) == 0) begin
                c  = $urandom_range(480, 700);
                ii = 1;
            end else begin
                c = $urandom_range(0, 24);
            end
            af = ($urandom_range(0, 4) == 0 && c > 0) ? $urandom_range(1, (c > DEPTH) ? DEPTH : c) : 0;
            run_block(b, c, ii, 1, af, 1'($urandom_range(0, 1)), (af != 0) ? af : ((c > DEPTH) ? DEPTH : c));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
